rot_slice_scheduler: RTL and testbench

//  Sequences readout of the rotational frame buffer for the spinning LED column.

---
 rtl/rot_slice_scheduler_pkg.sv | 21 ++
 rtl/rot_period_meter.sv | 46 ++++
 rtl/rot_slice_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_rot_slice_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rot_slice_scheduler_pkg.sv
// Shared types for the rotational slice scheduler: FSM encodings and row word type.
package rot_pkg;

  localparam int unsigned ROW_W = 64;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    RUN
  } sched_state_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_ADDR,
    F_WAIT,
    F_PRESENT
  } fetch_state_t;

endpackage

// File: rtl/rot_period_meter.sv
// Rotation period meter: counts cycles since the last accepted index pulse,
// debounces index pulses closer than MIN_PERIOD, latches the measured period
// and flags a stall when the counter saturates at MAX_PERIOD.
module rot_period_meter #(
  parameter int unsigned PERIOD_W   = 24,
  parameter int unsigned MIN_PERIOD = 1000,
  parameter int unsigned MAX_PERIOD = 10_000_000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_index,
  input  logic                i_idle,
  output logic                o_accept,
  output logic                o_stall,
  output logic [PERIOD_W-1:0] o_period
);

  logic [PERIOD_W-1:0] r_count;
  logic [PERIOD_W-1:0] r_period;
  logic                w_at_max;
  logic                w_accept;

  assign w_at_max = (r_count == PERIOD_W'(MAX_PERIOD));
  // The first index after IDLE is always taken; otherwise it must be past the
  // debounce window, and a saturated counter means the stall has already won.
  assign w_accept = i_index && (i_idle || ((r_count >= PERIOD_W'(MIN_PERIOD)) && !w_at_max));

  // Period counter and latched period; the counter is zeroed on the index
  // cycle, so the span between pulses is the count plus that cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_period <= '0;
    end else if (w_accept) begin
      r_count <= '0;
      if (!i_idle) r_period <= r_count + 1'b1;
    end else if (!w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_accept = w_accept;
  assign o_stall  = w_at_max;
  assign o_period = r_period;

endmodule

// File: rtl/rot_slice_scheduler.sv
// Rotational frame buffer readout sequencer for the spinning LED column.
// Locks to the index pulse, splits each revolution into ROTATIONAL_RES slices
// and streams each slice's ROWS words to the LED driver over valid/ready.
// Optional feature macro: ROT_PHASE_OFFSET_EN adds phase_offset_in, which
// rotates the fetched slice relative to the sensor position.
module rot_slice_scheduler
  import rot_pkg::*;
#(
  parameter int unsigned ROTATIONAL_RES = 32,
  parameter int unsigned ROWS           = 64,
  parameter int unsigned PERIOD_W       = 24,
  parameter int unsigned MIN_PERIOD     = 1000,
  parameter int unsigned MAX_PERIOD     = 10_000_000,
  parameter int unsigned RD_LATENCY     = 2
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   index_in,
`ifdef ROT_PHASE_OFFSET_EN
  input  logic [$clog2(ROTATIONAL_RES)-1:0]      phase_offset_in,
`endif
  output logic [$clog2(ROWS*ROTATIONAL_RES)-1:0] addr_out,
  input  logic [ROW_W-1:0]                       row_in,
  output logic [ROW_W-1:0]                       row_out,
  output logic                                   row_valid_out,
  input  logic                                   row_ready_in,
  output logic [$clog2(ROTATIONAL_RES)-1:0]      slice_out,
  output logic                                   slice_start_out,
  output logic                                   spinning_out,
  output logic                                   blank_out,
  output logic                                   overrun_out
);

  localparam int unsigned SLICE_W = $clog2(ROTATIONAL_RES);
  localparam int unsigned ADDR_W  = $clog2(ROWS*ROTATIONAL_RES);
  localparam int unsigned ROWC_W  = $clog2(ROWS);
  localparam int unsigned WAIT_W  = $clog2(RD_LATENCY+1);

  sched_state_t        r_state, w_state_nxt;
  fetch_state_t        r_fstate, w_fstate_nxt;
  logic                w_idle, w_accept, w_stall, w_sync, w_run_nxt;
  logic [PERIOD_W-1:0] w_period, w_slice_len, w_timer_inc, r_timer;
  logic [SLICE_W-1:0]  r_slice, w_fetch_slice;
  logic                r_slice_start, r_overrun;
  logic [ROWC_W-1:0]   r_row;
  logic [WAIT_W-1:0]   r_wait;
  logic [ROW_W-1:0]    r_row_data;
  logic                w_hs, w_last_row, w_last_wait;

  assign w_idle = (r_state == IDLE);

  rot_period_meter #(
    .PERIOD_W  (PERIOD_W),
    .MIN_PERIOD(MIN_PERIOD),
    .MAX_PERIOD(MAX_PERIOD)
  ) u_meter (
    .i_clk   (clk_in),
    .i_rst_n (rst_in),
    .i_index (index_in),
    .i_idle  (w_idle),
    .o_accept(w_accept),
    .o_stall (w_stall),
    .o_period(w_period)
  );

  // Scheduler state register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Scheduler next state: lock after two accepted index pulses, drop on stall.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = MEASURE;
      MEASURE: if (w_stall) w_state_nxt = IDLE;
               else if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_stall) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_sync      = w_accept && !w_idle;
  assign w_run_nxt   = (w_state_nxt == RUN);
  assign w_slice_len = w_period >> SLICE_W;
  assign w_timer_inc = r_timer + 1'b1;

  // Slice timer: index resyncs to slice 0; the last slice holds until the next index.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_slice       <= '0;
      r_timer       <= '0;
      r_slice_start <= 1'b0;
    end else begin
      r_slice_start <= 1'b0;
      if (!w_run_nxt) begin
        r_slice <= '0;
        r_timer <= '0;
      end else if (w_sync) begin
        r_slice       <= '0;
        r_timer       <= '0;
        r_slice_start <= 1'b1;
      end else if (r_slice != SLICE_W'(ROTATIONAL_RES-1)) begin
        if (w_timer_inc >= w_slice_len) begin
          r_slice       <= r_slice + 1'b1;
          r_timer       <= '0;
          r_slice_start <= 1'b1;
        end else begin
          r_timer <= w_timer_inc;
        end
      end
    end
  end

`ifdef ROT_PHASE_OFFSET_EN
  assign w_fetch_slice = r_slice + phase_offset_in;
`else
  assign w_fetch_slice = r_slice;
`endif

  assign w_hs        = (r_fstate == F_PRESENT) && row_ready_in;
  assign w_last_row  = (r_row == ROWC_W'(ROWS-1));
  assign w_last_wait = (r_wait == WAIT_W'(RD_LATENCY-1));

  // Fetch state register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) r_fstate <= F_IDLE;
    else         r_fstate <= w_fstate_nxt;
  end

  // Fetch next state: a slice start always restarts at row 0, leaving RUN aborts.
  always_comb begin
    w_fstate_nxt = r_fstate;
    if (!w_run_nxt) begin
      w_fstate_nxt = F_IDLE;
    end else if (r_slice_start) begin
      w_fstate_nxt = F_ADDR;
    end else begin
      case (r_fstate)
        F_IDLE:    w_fstate_nxt = F_IDLE;
        F_ADDR:    w_fstate_nxt = F_WAIT;
        F_WAIT:    if (w_last_wait) w_fstate_nxt = F_PRESENT;
        F_PRESENT: if (row_ready_in) w_fstate_nxt = w_last_row ? F_IDLE : F_ADDR;
        default:   w_fstate_nxt = F_IDLE;
      endcase
    end
  end

  // Fetch datapath: row/wait counters, read-data capture and sticky overrun.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_row      <= '0;
      r_wait     <= '0;
      r_row_data <= '0;
      r_overrun  <= 1'b0;
    end else if (!w_run_nxt) begin
      r_row  <= '0;
      r_wait <= '0;
    end else if (r_slice_start) begin
      r_row  <= '0;
      r_wait <= '0;
      // Completing the last row on this very cycle still counts as on time.
      if ((r_fstate != F_IDLE) && !(w_hs && w_last_row)) r_overrun <= 1'b1;
    end else begin
      case (r_fstate)
        F_WAIT: begin
          if (w_last_wait) begin
            r_row_data <= row_in;
            r_wait     <= '0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        F_PRESENT: if (row_ready_in) r_row <= r_row + 1'b1;
        default: ;
      endcase
    end
  end

  assign addr_out        = (r_fstate == F_ADDR)
                         ? (ADDR_W'(w_fetch_slice) * ADDR_W'(ROWS) + ADDR_W'(r_row)) : '0;
  assign row_out         = r_row_data;
  assign row_valid_out   = (r_fstate == F_PRESENT);
  assign slice_out       = r_slice;
  assign slice_start_out = r_slice_start;
  assign spinning_out    = (r_state == RUN);
  assign blank_out       = (r_state != RUN);
  assign overrun_out     = r_overrun;

endmodule

// File: tb/tb_rot_slice_scheduler.sv
// Scoreboard bench for rot_slice_scheduler (RES=4, ROWS=4, MIN=16, MAX=1000, RD_LATENCY=2).
module tb_rot_slice_scheduler;

`ifdef ROT_PHASE_OFFSET_EN
  localparam int OFFS = 3;
`else
  localparam int OFFS = 0;
`endif
  localparam int C0 = 1300;

  typedef struct { int slice; int cyc; } slice_exp_t;
  typedef struct { logic [63:0] data; int cyc; } row_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        index = 1'b0;
  logic        ready = 1'b1;
  logic [1:0]  phase_offset = 2'(OFFS);
  logic [3:0]  addr;
  logic [63:0] row_in, row_out, p1, p2;
  logic        valid, slice_start, spinning, blank, overrun;
  logic [1:0]  slice;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  slice_exp_t sq[$];
  row_exp_t   rq[$];

  rot_slice_scheduler #(
    .ROTATIONAL_RES(4), .ROWS(4), .PERIOD_W(24),
    .MIN_PERIOD(16), .MAX_PERIOD(1000), .RD_LATENCY(2)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .index_in(index),
`ifdef ROT_PHASE_OFFSET_EN
    .phase_offset_in(phase_offset),
`endif
    .addr_out(addr), .row_in(row_in), .row_out(row_out),
    .row_valid_out(valid), .row_ready_in(ready),
    .slice_out(slice), .slice_start_out(slice_start),
    .spinning_out(spinning), .blank_out(blank), .overrun_out(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_word(input int unsigned a);
    return {16'hFACE, a[15:0], 16'hB00C, a[15:0] ^ 16'h5A5A};
  endfunction

  // Frame buffer model with two cycles of read latency.
  always @(posedge clk) begin
    p1 <= mem_word(32'(addr));
    p2 <= p1;
  end
  assign row_in = p2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_slice(input int k, input int s, input bit rows);
    slice_exp_t se;
    row_exp_t   re;
    se.slice = k;
    se.cyc   = s;
    sq.push_back(se);
    if (rows) begin
      for (int r = 0; r < 4; r++) begin
        re.data = mem_word(32'(((k + OFFS) % 4) * 4 + r));
        re.cyc  = s + 4 + 4 * r;
        rq.push_back(re);
      end
    end
  endtask

  task automatic exp_rev(input int idx_cyc);
    for (int k = 0; k < 4; k++) exp_slice(k, idx_cyc + 1 + 100 * k, 1'b1);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_index_at(input int c);
    wait_to(c);
    index = 1'b1;
    @(posedge clk);
    #1;
    index = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a slice start or a row handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (slice_start) begin
        if (sq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL slice_unexpected: got slice %0d at cyc %0d required none", slice, cyc);
        end else begin
          slice_exp_t e;
          e = sq.pop_front();
          chk("slice_idx", 64'(slice), 64'(e.slice));
          chk("slice_cyc", 64'(cyc), 64'(e.cyc));
        end
      end
      if (valid && ready) begin
        if (rq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL row_unexpected: got %0h at cyc %0d required none", row_out, cyc);
        end else begin
          row_exp_t e;
          e = rq.pop_front();
          chk("row_data", row_out, e.data);
          chk("row_cyc", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    int bad;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_blank", 64'(blank), 64'd1);
    chk("rst_spinning", 64'(spinning), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_slice", 64'(slice), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_row_out", row_out, 64'd0);
    rst_n = 1'b1;

    // No index: stays dark beyond the stall window.
    bad = 0;
    repeat (1200) begin
      @(posedge clk);
      #1;
      if (!blank || spinning || valid || slice_start) bad++;
    end
    chk("idle_quiet", 64'(bad), 64'd0);

    // Lock: first index measures, second starts running.
    drive_index_at(C0);
    chk("measure_spinning", 64'(spinning), 64'd0);
    exp_rev(C0 + 400);
    drive_index_at(C0 + 400);
    chk("run_spinning", 64'(spinning), 64'd1);
    chk("run_blank", 64'(blank), 64'd0);
    exp_rev(C0 + 800);
    drive_index_at(C0 + 800);

    // Glitch 8 cycles after an index is debounced away.
    exp_rev(C0 + 1200);
    drive_index_at(C0 + 1200);
    drive_index_at(C0 + 1208);
    exp_rev(C0 + 1600);
    drive_index_at(C0 + 1600);

    // Index stops: stall exactly MAX_PERIOD cycles after the last accepted index.
    wait_to(C0 + 2601);
    chk("pre_stall_spinning", 64'(spinning), 64'd1);
    wait_to(C0 + 2602);
    chk("stall_spinning", 64'(spinning), 64'd0);
    chk("stall_blank", 64'(blank), 64'd1);
    chk("stall_valid", 64'(valid), 64'd0);

    // Relock needs two pulses.
    drive_index_at(C0 + 2700);
    wait_to(C0 + 2750);
    chk("relock1_spinning", 64'(spinning), 64'd0);

    // Overrun revolution: ready low 150 cycles in slice 1.
    exp_slice(0, C0 + 3101, 1'b1);
    exp_slice(1, C0 + 3201, 1'b0);
    exp_slice(2, C0 + 3301, 1'b0);
    begin
      row_exp_t re;
      for (int r = 0; r < 4; r++) begin
        re.data = mem_word(32'(((2 + OFFS) % 4) * 4 + r));
        re.cyc  = C0 + 3353 + 4 * r;
        rq.push_back(re);
      end
    end
    exp_slice(3, C0 + 3401, 1'b1);
    drive_index_at(C0 + 3100);
    chk("relock2_spinning", 64'(spinning), 64'd1);
    wait_to(C0 + 3203);
    ready = 1'b0;
    wait_to(C0 + 3300);
    chk("overrun_before", 64'(overrun), 64'd0);
    wait_to(C0 + 3302);
    chk("overrun_set", 64'(overrun), 64'd1);
    wait_to(C0 + 3353);
    ready = 1'b1;

    exp_rev(C0 + 3500);
    drive_index_at(C0 + 3500);
    wait_to(C0 + 3900);
    chk("overrun_sticky", 64'(overrun), 64'd1);
    chk("slice_q_left", 64'(sq.size()), 64'd0);
    chk("row_q_left", 64'(rq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at cyc %0d required finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
